// File: rtl/stg0pc_pkg.sv
// -----------------------------------------------------------------------------
// stg0pc_pkg
// Shared definitions for the fetch program-counter sequencer (stg0pc).
//   SIZE_ADDR      width of every fetch address
//   ST_*           2-bit sequencer state encodings
//   TRAP_VEC_DEF   default trap target used when no explicit trap PC is chosen
//   trap_target()  selects between the fixed trap vector and an explicit target
// -----------------------------------------------------------------------------
package stg0pc_pkg;

   localparam int SIZE_ADDR = 16;

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam logic [SIZE_ADDR-1:0] TRAP_VEC_DEF = 16'h0010;

   // Trap destination: explicit PC when sel is set, otherwise the fixed vector.
   function automatic logic [SIZE_ADDR-1:0] trap_target(
      input logic                 sel,
      input logic [SIZE_ADDR-1:0] explicit_pc,
      input logic [SIZE_ADDR-1:0] vec_pc
   );
      logic [SIZE_ADDR-1:0] tgt;
      if (sel) begin
         tgt = explicit_pc;
      end else begin
         tgt = vec_pc;
      end
      return tgt;
   endfunction

endpackage

// File: rtl/stg0pc_redir.sv
// -----------------------------------------------------------------------------
// stg0pc_redir
// Redirect-target selection plus the pending-redirect register used while the
// sequencer is stalled.
// Ports:
//   iw_clk, iw_rst_n           clock / async active-low reset
//   branch_valid, branch_pc    branch redirect request and target
//   trap_valid, trap_vec_sel,
//   trap_pc                    trap redirect request and target selection
//   capture                    latch the merged redirect into the pending reg
//   clear                      drop the pending redirect (it has been consumed)
//   req, req_pc                redirect requested this cycle and its target
//   merged_valid, merged_pc    pending redirect merged with this cycle's request
// -----------------------------------------------------------------------------
module stg0pc_redir
   import stg0pc_pkg::*;
#(
   parameter logic [SIZE_ADDR-1:0] TRAP_VEC = TRAP_VEC_DEF
) (
   input  logic                 iw_clk,
   input  logic                 iw_rst_n,
   input  logic                 branch_valid,
   input  logic [SIZE_ADDR-1:0] branch_pc,
   input  logic                 trap_valid,
   input  logic                 trap_vec_sel,
   input  logic [SIZE_ADDR-1:0] trap_pc,
   input  logic                 capture,
   input  logic                 clear,
   output logic                 req,
   output logic [SIZE_ADDR-1:0] req_pc,
   output logic                 merged_valid,
   output logic [SIZE_ADDR-1:0] merged_pc
);

   logic                 pend_valid_r;
   logic                 pend_trap_r;
   logic [SIZE_ADDR-1:0] pend_pc_r;
   logic [SIZE_ADDR-1:0] trap_tgt_s;
   logic                 merged_trap_s;

   assign trap_tgt_s = trap_target(trap_vec_sel, trap_pc, TRAP_VEC);

   // Current-cycle redirect: a trap always beats a simultaneous branch.
   always_comb begin
      req    = trap_valid | branch_valid;
      req_pc = branch_pc;
      if (trap_valid) begin
         req_pc = trap_tgt_s;
      end else begin
         req_pc = branch_pc;
      end
   end

   // Merge with the pending slot: a new trap replaces anything, a new branch
   // only replaces an empty slot or a pending branch, never a pending trap.
   always_comb begin
      merged_valid  = pend_valid_r;
      merged_trap_s = pend_trap_r;
      merged_pc     = pend_pc_r;
      if (trap_valid) begin
         merged_valid  = 1'b1;
         merged_trap_s = 1'b1;
         merged_pc     = trap_tgt_s;
      end else if (branch_valid && !pend_trap_r) begin
         merged_valid  = 1'b1;
         merged_trap_s = 1'b0;
         merged_pc     = branch_pc;
      end else begin
         merged_valid  = pend_valid_r;
         merged_trap_s = pend_trap_r;
         merged_pc     = pend_pc_r;
      end
   end

   // Pending redirect register, written while stalled, emptied when consumed.
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         pend_valid_r <= 1'b0;
         pend_trap_r  <= 1'b0;
         pend_pc_r    <= {SIZE_ADDR{1'b0}};
      end else if (capture) begin
         pend_valid_r <= merged_valid;
         pend_trap_r  <= merged_trap_s;
         pend_pc_r    <= merged_pc;
      end else if (clear) begin
         pend_valid_r <= 1'b0;
         pend_trap_r  <= 1'b0;
         pend_pc_r    <= {SIZE_ADDR{1'b0}};
      end else begin
         pend_valid_r <= pend_valid_r;
         pend_trap_r  <= pend_trap_r;
         pend_pc_r    <= pend_pc_r;
      end
   end

endmodule

// File: rtl/stg0pc.sv
// -----------------------------------------------------------------------------
// stg0pc
// Program-counter sequencer for the fetch front end. Produces sequential fetch
// addresses and applies stall, branch, trap and halt requests; every applied
// redirect is followed by a one-cycle flush pulse.
// Ports:
//   iw_clk, iw_rst_n                       clock / async active-low reset
//   iw_stall                               hold the current PC
//   iw_branch_valid, iw_branch_pc          branch redirect pulse and target
//   iw_trap_valid, iw_trap_vec_sel,
//   iw_trap_pc                             trap redirect pulse and target select
//   iw_halt                                stop fetching
//   ow_pc, ow_pc_valid                     registered fetch address / valid
//   ow_flush                               kill the in-flight fetch (1 cycle)
//   ow_halted                              sequencer is halted
// -----------------------------------------------------------------------------
module stg0pc
   import stg0pc_pkg::*;
#(
   parameter logic [SIZE_ADDR-1:0] RESET_PC = 16'h0000,
   parameter logic [SIZE_ADDR-1:0] PC_INC   = 16'h0001,
   parameter logic [SIZE_ADDR-1:0] TRAP_VEC = TRAP_VEC_DEF
) (
   input  logic                 iw_clk,
   input  logic                 iw_rst_n,
   input  logic                 iw_stall,
   input  logic                 iw_branch_valid,
   input  logic [SIZE_ADDR-1:0] iw_branch_pc,
   input  logic                 iw_trap_valid,
   input  logic                 iw_trap_vec_sel,
   input  logic [SIZE_ADDR-1:0] iw_trap_pc,
   input  logic                 iw_halt,
   output logic [SIZE_ADDR-1:0] ow_pc,
   output logic                 ow_pc_valid,
   output logic                 ow_flush,
   output logic                 ow_halted
);

   logic [1:0]           state_r;
   logic [SIZE_ADDR-1:0] pc_r;
   logic                 flush_r;
   logic                 valid_r;
   logic                 halted_r;

   logic [1:0]           state_nxt_s;
   logic [SIZE_ADDR-1:0] pc_nxt_s;
   logic                 flush_nxt_s;
   logic                 capture_s;
   logic                 clear_s;
   logic                 req_s;
   logic [SIZE_ADDR-1:0] req_pc_s;
   logic                 merged_valid_s;
   logic [SIZE_ADDR-1:0] merged_pc_s;

   stg0pc_redir #(
      .TRAP_VEC (TRAP_VEC)
   ) u_redir (
      .iw_clk       (iw_clk),
      .iw_rst_n     (iw_rst_n),
      .branch_valid (iw_branch_valid),
      .branch_pc    (iw_branch_pc),
      .trap_valid   (iw_trap_valid),
      .trap_vec_sel (iw_trap_vec_sel),
      .trap_pc      (iw_trap_pc),
      .capture      (capture_s),
      .clear        (clear_s),
      .req          (req_s),
      .req_pc       (req_pc_s),
      .merged_valid (merged_valid_s),
      .merged_pc    (merged_pc_s)
   );

   // Next-state / next-PC decision; addition wraps modulo 2^SIZE_ADDR.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      flush_nxt_s = 1'b0;
      capture_s   = 1'b0;
      clear_s     = 1'b0;
      case (state_r)
         ST_BOOT: begin
            state_nxt_s = ST_RUN;
         end
         ST_RUN: begin
            if (req_s) begin
               pc_nxt_s    = req_pc_s;
               flush_nxt_s = 1'b1;
            end else if (iw_halt) begin
               state_nxt_s = ST_HALT;
            end else if (iw_stall) begin
               state_nxt_s = ST_STALL;
            end else begin
               pc_nxt_s = pc_r + PC_INC;
            end
         end
         ST_STALL: begin
            // Halt is deliberately not looked at here; it is re-sampled in RUN.
            if (iw_stall) begin
               capture_s = 1'b1;
            end else begin
               clear_s     = 1'b1;
               state_nxt_s = ST_RUN;
               if (merged_valid_s) begin
                  pc_nxt_s    = merged_pc_s;
                  flush_nxt_s = 1'b1;
               end else begin
                  pc_nxt_s = pc_r + PC_INC;
               end
            end
         end
         ST_HALT: begin
            if (req_s) begin
               pc_nxt_s    = req_pc_s;
               flush_nxt_s = 1'b1;
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_HALT;
            end
         end
         default: begin
            state_nxt_s = ST_BOOT;
            pc_nxt_s    = RESET_PC;
         end
      endcase
   end

   // Sequencer state and registered outputs (valid/halted decoded from next state).
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         state_r  <= ST_BOOT;
         pc_r     <= RESET_PC;
         flush_r  <= 1'b0;
         valid_r  <= 1'b0;
         halted_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         pc_r     <= pc_nxt_s;
         flush_r  <= flush_nxt_s;
         valid_r  <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_STALL);
         halted_r <= (state_nxt_s == ST_HALT);
      end
   end

   assign ow_pc       = pc_r;
   assign ow_pc_valid = valid_r;
   assign ow_flush    = flush_r;
   assign ow_halted   = halted_r;

endmodule

// File: tb/tb_stg0pc.sv
module tb_stg0pc;

   logic        iw_clk = 1'b0;
   logic        iw_rst_n;
   logic        iw_stall;
   logic        iw_branch_valid;
   logic [15:0] iw_branch_pc;
   logic        iw_trap_valid;
   logic        iw_trap_vec_sel;
   logic [15:0] iw_trap_pc;
   logic        iw_halt;
   logic [15:0] ow_pc;
   logic        ow_pc_valid;
   logic        ow_flush;
   logic        ow_halted;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: fetch mode, current PC, flush flag, pending redirect.
   localparam int M_BOOT = 0, M_RUN = 1, M_STALL = 2, M_HALT = 3;
   int          m_mode;
   logic [15:0] m_pc;
   bit          m_flush;
   int          m_pend_kind;   // 0 none, 1 branch, 2 trap
   logic [15:0] m_pend_pc;

   wire [18:0] dut_obs = {ow_pc, ow_pc_valid, ow_flush, ow_halted};

   stg0pc dut (
      .iw_clk          (iw_clk),
      .iw_rst_n        (iw_rst_n),
      .iw_stall        (iw_stall),
      .iw_branch_valid (iw_branch_valid),
      .iw_branch_pc    (iw_branch_pc),
      .iw_trap_valid   (iw_trap_valid),
      .iw_trap_vec_sel (iw_trap_vec_sel),
      .iw_trap_pc      (iw_trap_pc),
      .iw_halt         (iw_halt),
      .ow_pc           (ow_pc),
      .ow_pc_valid     (ow_pc_valid),
      .ow_flush        (ow_flush),
      .ow_halted       (ow_halted)
   );

   always #5 iw_clk = ~iw_clk;

   function automatic logic [18:0] exp_obs();
      return {m_pc, (m_mode == M_RUN || m_mode == M_STALL), m_flush, (m_mode == M_HALT)};
   endfunction

   task automatic model_reset();
      m_mode = M_BOOT; m_pc = 16'h0000; m_flush = 1'b0; m_pend_kind = 0; m_pend_pc = 16'h0000;
   endtask

   // One clock edge of the behaviour, using the inputs presented before the edge.
   task automatic model_step();
      bit          req;
      logic [15:0] tgt;
      req = iw_trap_valid || iw_branch_valid;
      tgt = iw_trap_valid ? (iw_trap_vec_sel ? iw_trap_pc : 16'h0010) : iw_branch_pc;
      m_flush = 1'b0;
      if (!iw_rst_n) begin
         model_reset();
      end else if (m_mode == M_BOOT) begin
         m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
         if (req) begin m_pc = tgt; m_flush = 1'b1; end
         else if (iw_halt) m_mode = M_HALT;
         else if (iw_stall) m_mode = M_STALL;
         else m_pc = m_pc + 16'd1;
      end else if (m_mode == M_STALL) begin
         if (iw_trap_valid) begin m_pend_kind = 2; m_pend_pc = tgt; end
         else if (iw_branch_valid && m_pend_kind != 2) begin m_pend_kind = 1; m_pend_pc = iw_branch_pc; end
         if (!iw_stall) begin
            if (m_pend_kind != 0) begin m_pc = m_pend_pc; m_flush = 1'b1; end
            else m_pc = m_pc + 16'd1;
            m_pend_kind = 0;
            m_mode = M_RUN;
         end
      end else begin
         if (req) begin m_pc = tgt; m_flush = 1'b1; m_mode = M_RUN; end
      end
   endtask

   // Advance one cycle; redirect inputs are single-cycle pulses.
   task automatic tick();
      @(posedge iw_clk);
      model_step();
      #1;
      iw_branch_valid = 1'b0;
      iw_trap_valid   = 1'b0;
   endtask

   task automatic test_reset();
      iw_rst_n = 1'b0; iw_stall = 1'b0; iw_branch_valid = 1'b0; iw_branch_pc = 16'h0;
      iw_trap_valid = 1'b0; iw_trap_vec_sel = 1'b0; iw_trap_pc = 16'h0; iw_halt = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (dut_obs !== 19'h0) begin n_bad++; $display("FAIL reset_vals: got %h want %h", dut_obs, 19'h0); end
      tick(); tick();
      iw_rst_n = 1'b1;
      n_vec++;
      if (ow_pc_valid !== 1'b0 || dut_obs !== exp_obs()) begin
         n_bad++; $display("FAIL boot_cycle: got %h want %h", dut_obs, exp_obs());
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_vec++;
         if (ow_pc !== 16'(i) || ow_pc_valid !== 1'b1 || dut_obs !== exp_obs()) begin
            n_bad++; $display("FAIL seq_fetch%0d: got %h want pc %0d model %h", i, dut_obs, i, exp_obs());
         end
      end
   endtask

   task automatic test_branch();
      for (int i = 0; i < 8 && m_pc != 16'h5; i++) tick();
      n_vec++;
      if (ow_pc !== 16'h5) begin n_bad++; $display("FAIL reach_pc5: got %h want 0005", ow_pc); end
      iw_branch_valid = 1'b1; iw_branch_pc = 16'h0040;
      tick();
      n_vec++;
      if (ow_pc !== 16'h0040 || ow_flush !== 1'b1 || dut_obs !== exp_obs()) begin
         n_bad++; $display("FAIL branch_tgt: got %h want %h", dut_obs, exp_obs());
      end
      tick();
      n_vec++;
      if (ow_pc !== 16'h0041 || ow_flush !== 1'b0 || dut_obs !== exp_obs()) begin
         n_bad++; $display("FAIL branch_next: got %h want %h", dut_obs, exp_obs());
      end
   endtask

   task automatic test_trap_vs_branch();
      iw_trap_valid = 1'b1; iw_trap_vec_sel = 1'b0; iw_trap_pc = 16'h0777;
      iw_branch_valid = 1'b1; iw_branch_pc = 16'h0080;
      tick();
      n_vec++;
      if (ow_pc !== 16'h0010 || ow_flush !== 1'b1 || dut_obs !== exp_obs()) begin
         n_bad++; $display("FAIL trap_prio: got %h want %h", dut_obs, exp_obs());
      end
      tick();
      n_vec++;
      if (ow_pc !== 16'h0011 || ow_flush !== 1'b0) begin
         n_bad++; $display("FAIL trap_single_flush: got %h want pc 0011 flush 0", dut_obs);
      end
   endtask

   task automatic test_stall_branch();
      iw_branch_valid = 1'b1; iw_branch_pc = 16'h0007;
      tick();
      iw_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin iw_branch_valid = 1'b1; iw_branch_pc = 16'h0020; end
         tick();
         n_vec++;
         if (ow_pc !== 16'h0007 || ow_pc_valid !== 1'b1 || ow_flush !== 1'b0 || dut_obs !== exp_obs()) begin
            n_bad++; $display("FAIL stall_hold%0d: got %h want %h", i, dut_obs, exp_obs());
         end
      end
      iw_stall = 1'b0;
      tick();
      n_vec++;
      if (ow_pc !== 16'h0020 || ow_flush !== 1'b1 || dut_obs !== exp_obs()) begin
         n_bad++; $display("FAIL stall_redirect: got %h want %h", dut_obs, exp_obs());
      end
      tick();
      n_vec++;
      if (ow_pc !== 16'h0021 || ow_flush !== 1'b0) begin
         n_bad++; $display("FAIL stall_after: got %h want pc 0021 flush 0", dut_obs);
      end
   endtask

   task automatic test_halt();
      iw_branch_valid = 1'b1; iw_branch_pc = 16'h0009;
      tick();
      iw_halt = 1'b1;
      tick();
      iw_stall = 1'b1;
      tick();
      n_vec++;
      if (ow_halted !== 1'b1 || ow_pc_valid !== 1'b0 || ow_pc !== 16'h0009 || dut_obs !== exp_obs()) begin
         n_bad++; $display("FAIL halt_state: got %h want %h", dut_obs, exp_obs());
      end
      iw_halt = 1'b0; iw_stall = 1'b0;
      iw_trap_valid = 1'b1; iw_trap_vec_sel = 1'b1; iw_trap_pc = 16'h0100;
      tick();
      n_vec++;
      if (ow_pc !== 16'h0100 || ow_flush !== 1'b1 || ow_halted !== 1'b0 || ow_pc_valid !== 1'b1) begin
         n_bad++; $display("FAIL halt_exit: got %h want pc 0100 valid 1 flush 1 halted 0", dut_obs);
      end
   endtask

   task automatic test_back_to_back();
      iw_branch_valid = 1'b1; iw_branch_pc = 16'h0030;
      tick();
      iw_branch_valid = 1'b1; iw_branch_pc = 16'h0050;
      tick();
      n_vec++;
      if (ow_pc !== 16'h0050 || ow_flush !== 1'b1 || dut_obs !== exp_obs()) begin
         n_bad++; $display("FAIL b2b_second: got %h want %h", dut_obs, exp_obs());
      end
      tick();
      n_vec++;
      if (ow_pc !== 16'h0051 || ow_flush !== 1'b0) begin
         n_bad++; $display("FAIL b2b_after: got %h want pc 0051 flush 0", dut_obs);
      end
   endtask

   task automatic test_wrap();
      iw_branch_valid = 1'b1; iw_branch_pc = 16'hFFFF;
      tick();
      tick();
      n_vec++;
      if (ow_pc !== 16'h0000 || ow_flush !== 1'b0 || ow_pc_valid !== 1'b1) begin
         n_bad++; $display("FAIL pc_wrap: got %h want pc 0000 valid 1 flush 0", dut_obs);
      end
   endtask

   task automatic test_reset_mid();
      iw_stall = 1'b1;
      tick();
      iw_branch_valid = 1'b1; iw_branch_pc = 16'h0060;
      tick();
      iw_rst_n = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (dut_obs !== 19'h0) begin n_bad++; $display("FAIL mid_reset: got %h want %h", dut_obs, 19'h0); end
      iw_stall = 1'b0;
      tick();
      iw_rst_n = 1'b1;
      tick();
      n_vec++;
      if (ow_pc !== 16'h0000 || ow_pc_valid !== 1'b1 || ow_flush !== 1'b0) begin
         n_bad++; $display("FAIL post_reset_first: got %h want pc 0000 valid 1 flush 0", dut_obs);
      end
      tick();
      n_vec++;
      if (ow_pc !== 16'h0001 || ow_flush !== 1'b0) begin
         n_bad++; $display("FAIL pending_cleared: got %h want pc 0001 flush 0", dut_obs);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         iw_stall        = ($urandom_range(0, 2) == 0);
         iw_halt         = ($urandom_range(0, 15) == 0);
         iw_branch_valid = ($urandom_range(0, 5) == 0);
         iw_branch_pc    = 16'($urandom);
         iw_trap_valid   = ($urandom_range(0, 9) == 0);
         iw_trap_vec_sel = 1'($urandom);
         iw_trap_pc      = 16'($urandom);
         tick();
         n_vec++;
         if (dut_obs !== exp_obs()) begin
            n_bad++; $display("FAIL random%0d: got %h want %h", i, dut_obs, exp_obs());
         end
      end
      iw_stall = 1'b0; iw_halt = 1'b0;
   endtask

   initial begin
      test_reset();
      test_branch();
      test_trap_vs_branch();
      test_stall_branch();
      test_halt();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
